cpuc_mem_dma: RTL and testbench

- Block-transfer initiator for the CPUC multi-port data RAM. It drives one RAM port as a read port and a second port as a write port.
- Copies `length` words from `src_addr` to `dst_addr`, or fills a region with a constant.
- Issues one word per granted cycle. It relies on the RAM's combinational read (q valid in the same cycle as the address) and its write-on-clock-edge.
- Sits between the control/MMIO layer and the RAM. Core, debug and DMA traffic share RAM ports by an external grant.

---
 rtl/cpuc_mem_dma_pkg.sv | 9 +
 rtl/cpuc_mem_dma_if.sv | 12 +
 rtl/cpuc_mem_dma_addr_gen.sv | 17 +
 rtl/cpuc_mem_dma.sv | 73 +++++++
 tb/tb_cpuc_mem_dma.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cpuc_mem_dma_pkg.sv
// cpuc_mem_dma_pkg: shared sizes, state and mode types for the CPUC block-transfer DMA
package cpuc_mem_dma_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 16;
  localparam int MEM_SIZE = 64;
  localparam int LEN_WIDTH = ADDR_WIDTH + 1;
  typedef enum logic [1:0] {DMA_IDLE, DMA_RUN, DMA_DONE} t_dma_state;
  typedef enum logic {DMA_COPY, DMA_FILL} t_dma_mode;
endpackage

// File: rtl/cpuc_mem_dma_if.sv
// cpuc_mem_dma_if: DMA-side view of one RAM read port and one RAM write port plus the shared grant
interface cpuc_mem_dma_if;
  import cpuc_mem_dma_pkg::*;
  logic mem_gnt;
  logic [ADDR_WIDTH-1:0] rd_address;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] wr_address;
  logic wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  modport master (input mem_gnt, rd_q, output rd_address, wr_address, wr_en, wr_data);
  modport slave (output mem_gnt, rd_q, input rd_address, wr_address, wr_en, wr_data);
endinterface

// File: rtl/cpuc_mem_dma_addr_gen.sv
// cpuc_mem_dma_addr_gen: loadable address counter stepping up or down by one, holding when not stepped
module cpuc_mem_dma_addr_gen
  import cpuc_mem_dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  down,
  input  logic [ADDR_WIDTH-1:0] base,
  output logic [ADDR_WIDTH-1:0] addr
);
  always_ff @(posedge clk)
    if (rst) addr <= '0;
    else if (load) addr <= base;
    else if (step) addr <= addr + (down ? '1 : ADDR_WIDTH'(1));
endmodule

// File: rtl/cpuc_mem_dma.sv
// cpuc_mem_dma: block copy/fill initiator driving one RAM read port and one RAM write port under an external grant
module cpuc_mem_dma
  import cpuc_mem_dma_pkg::*;
#(
  parameter bit CHECK_BOUNDS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [DATA_WIDTH-1:0] fill_data,
  cpuc_mem_dma_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  words_done
);
  t_dma_state state, state_n;
  t_dma_mode mode_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] cur_src, cur_dst, off, src_base, dst_base;
  logic accept, zero, oob, desc, desc_q, adv, last;
  always_comb begin
    accept = state == DMA_IDLE && start;
    zero = length == '0;
    oob = CHECK_BOUNDS && ((!mode && {1'b0, src_addr} + length > LEN_WIDTH'(MEM_SIZE))
                           || {1'b0, dst_addr} + length > LEN_WIDTH'(MEM_SIZE));
    desc = !mode && dst_addr > src_addr;
    off = length[ADDR_WIDTH-1:0] + '1;
    src_base = desc ? src_addr + off : src_addr;
    dst_base = desc ? dst_addr + off : dst_addr;
    adv = state == DMA_RUN && bus.mem_gnt;
    last = adv && words_done + LEN_WIDTH'(1) == len_q;
    state_n = state == DMA_IDLE ? (accept ? ((zero || oob) ? DMA_DONE : DMA_RUN) : DMA_IDLE)
            : state == DMA_RUN ? (last ? DMA_DONE : DMA_RUN) : DMA_IDLE;
    busy = state == DMA_RUN;
    done = state == DMA_DONE;
    bus.wr_en = adv;
    bus.rd_address = (busy && mode_q == DMA_COPY) ? cur_src : '0;
    bus.wr_address = busy ? cur_dst : '0;
    bus.wr_data = !busy ? '0 : mode_q == DMA_FILL ? fill_q : bus.rd_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= DMA_IDLE;
      mode_q <= DMA_COPY;
      fill_q <= '0;
      len_q <= '0;
      desc_q <= 1'b0;
      words_done <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        mode_q <= t_dma_mode'(mode);
        fill_q <= fill_data;
        len_q <= length;
        desc_q <= desc;
        words_done <= '0;
        err <= oob && !zero;
      end else if (adv) words_done <= words_done + LEN_WIDTH'(1);
    end
  cpuc_mem_dma_addr_gen u_src (
    .clk(clk), .rst(rst), .load(accept), .step(adv), .down(desc_q), .base(src_base), .addr(cur_src)
  );
  cpuc_mem_dma_addr_gen u_dst (
    .clk(clk), .rst(rst), .load(accept), .step(adv), .down(desc_q), .base(dst_base), .addr(cur_dst)
  );
endmodule

// File: tb/tb_cpuc_mem_dma.sv
// tb_cpuc_mem_dma: scoreboard bench comparing DMA writes and completions against a memmove/memset reference
module tb_cpuc_mem_dma;
  import cpuc_mem_dma_pkg::*;
  logic clk = 1'b0;
  logic rst, start, mode;
  logic [ADDR_WIDTH-1:0] src_addr, dst_addr;
  logic [LEN_WIDTH-1:0] length;
  logic [DATA_WIDTH-1:0] fill_data;
  logic busy, done, err;
  logic [LEN_WIDTH-1:0] words_done;
  logic pl_we = 1'b0;
  logic [ADDR_WIDTH-1:0] pl_a;
  logic [DATA_WIDTH-1:0] pl_d;
  logic [DATA_WIDTH-1:0] ram [MEM_SIZE];
  logic [DATA_WIDTH-1:0] ref_mem [MEM_SIZE];
  typedef struct packed {logic [ADDR_WIDTH-1:0] a; logic [DATA_WIDTH-1:0] d;} wr_t;
  typedef struct packed {logic [LEN_WIDTH-1:0] wd; logic e;} dn_t;
  wr_t wq[$];
  dn_t dq[$];
  int n_cmp = 0, n_bad = 0;
  cpuc_mem_dma_if bus ();
  cpuc_mem_dma #(.CHECK_BOUNDS(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .fill_data(fill_data), .bus(bus), .busy(busy), .done(done), .err(err),
    .words_done(words_done)
  );
  always #5 clk = ~clk;
  assign bus.rd_q = ram[bus.rd_address];
  always @(posedge clk)
    if (bus.wr_en === 1'b1) ram[bus.wr_address] <= bus.wr_data;
    else if (pl_we) ram[pl_a] <= pl_d;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic mem_chk(string name);
    int bad = -1;
    for (int i = 0; i < MEM_SIZE; i++) if (bad < 0 && ram[i] !== ref_mem[i]) bad = i;
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s: ram[%0d]=%0h expected %0h", name, bad, ram[bad], ref_mem[bad]);
    end
  endtask
  task automatic poke(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    pl_we = 1'b1;
    pl_a = a;
    pl_d = d;
    ref_mem[a] = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask
  task automatic chk_idle_outputs(string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wr_en"}, bus.wr_en, 0);
    chk({tag, "_rd_address"}, bus.rd_address, 0);
    chk({tag, "_wr_address"}, bus.wr_address, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_words_done"}, words_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0h data %0h with no write pending", bus.wr_address, bus.wr_data);
      end else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_address", bus.wr_address, e.a);
        chk("wr_data", bus.wr_data, e.d);
        ref_mem[e.a] = e.d;
      end
    end
    if (done === 1'b1) begin
      if (dq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: done pulse with no transfer completion pending");
      end else begin
        dn_t e;
        e = dq.pop_front();
        chk("done_words_done", words_done, e.wd);
        chk("done_err", err, e.e);
      end
    end
  end
  // gmode: 0 always granted, 1 random grant, 2 grant pattern 1,0,0,1,1,...
  task automatic run_xfer(input bit m, input int s, input int d, input int n, input logic [DATA_WIDTH-1:0] f,
                          input int gmode, input int rst_at, input bit dup);
    logic [DATA_WIDTH-1:0] snap [MEM_SIZE];
    bit rej, nowr, g;
    int grants = 0, exp_k, got_k = -1;
    rej = n != 0 && ((!m && s + n > MEM_SIZE) || d + n > MEM_SIZE);
    nowr = rej || n == 0;
    snap = ref_mem;
    if (!nowr)
      for (int k = 0; k < n; k++) begin
        int i;
        wr_t w;
        i = (!m && d > s) ? n - 1 - k : k;
        w.a = ADDR_WIDTH'(d + i);
        w.d = m ? f : snap[(s + i) % MEM_SIZE];
        wq.push_back(w);
      end
    if (rst_at < 0) dq.push_back({LEN_WIDTH'(nowr ? 0 : n), rej});
    start = 1'b1;
    mode = m;
    src_addr = ADDR_WIDTH'(s);
    dst_addr = ADDR_WIDTH'(d);
    length = LEN_WIDTH'(n);
    fill_data = f;
    bus.mem_gnt = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode = ~m;
    src_addr = ADDR_WIDTH'($urandom);
    dst_addr = ADDR_WIDTH'($urandom);
    length = LEN_WIDTH'($urandom);
    fill_data = DATA_WIDTH'($urandom);
    exp_k = nowr ? 0 : -1;
    for (int r = 0; r < 400; r++) begin
      g = gmode == 0 ? 1'b1 : gmode == 2 ? (r != 1 && r != 2) : ($urandom_range(0, 3) != 0);
      bus.mem_gnt = g;
      if (r == 0) chk("err_after_start", err, rej);
      if (dup && r == 1) begin
        start = 1'b1;
        mode = ~m;
        src_addr = ADDR_WIDTH'(s + 7);
        dst_addr = ADDR_WIDTH'(d + 3);
        length = LEN_WIDTH'(2);
      end
      if (r == rst_at) rst = 1'b1;
      if (exp_k < 0 && g) begin
        grants++;
        if (grants == n) exp_k = r + 1;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        got_k = r;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (r == rst_at) begin
        chk_idle_outputs("after_reset");
        rst = 1'b0;
        chk("writes_left_at_reset", wq.size(), n - rst_at - 1);
        wq.delete();
        break;
      end
    end
    if (rst_at < 0) begin
      if (got_k < 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: no done within 400 cycles, expected after %0d", exp_k);
      end else chk("done_latency", got_k, exp_k);
      @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_words_done", words_done, nowr ? 0 : n);
      chk("idle_err", err, rej);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("writes_drained", wq.size(), 0);
    mem_chk("ram_contents");
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length = '0;
    fill_data = '0;
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) poke(ADDR_WIDTH'(i), DATA_WIDTH'($urandom));
    chk_idle_outputs("reset");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) poke(ADDR_WIDTH'(10 + i), DATA_WIDTH'(16'hA0 + i));
    run_xfer(0, 10, 40, 4, 0, 0, -1, 0);
    for (int i = 0; i < 4; i++) poke(ADDR_WIDTH'(i), DATA_WIDTH'(i + 1));
    run_xfer(0, 0, 1, 4, 0, 0, -1, 0);
    run_xfer(0, 1, 0, 4, 0, 0, -1, 0);
    run_xfer(1, 0, 20, 3, 16'hDEAD, 2, -1, 0);
    run_xfer(1, 0, MEM_SIZE - 2, 3, 16'h5555, 0, -1, 0);
    run_xfer(0, 5, 6, 2, 0, 0, -1, 0);
    run_xfer(0, 60, 2, 5, 0, 0, -1, 0);
    run_xfer(0, 9, 9, 0, 0, 0, -1, 0);
    run_xfer(1, 0, 30, 8, 16'h1234, 0, 2, 0);
    run_xfer(1, 0, 30, 8, 16'h4321, 0, -1, 0);
    run_xfer(0, 10, 50, 4, 0, 0, -1, 1);
    run_xfer(0, 17, 17, 6, 0, 1, -1, 0);
    run_xfer(1, 0, 0, MEM_SIZE, 16'hBEEF, 1, -1, 0);
    for (int i = 0; i < MEM_SIZE; i++) poke(ADDR_WIDTH'(i), DATA_WIDTH'($urandom));
    run_xfer(0, 0, 0, MEM_SIZE, 0, 1, -1, 0);
    for (int t = 0; t < 40; t++) begin
      int n;
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, MEM_SIZE)) : int'($urandom_range(0, 12));
      run_xfer(1'($urandom), int'($urandom_range(0, MEM_SIZE - 1)), int'($urandom_range(0, MEM_SIZE - 1)), n,
               DATA_WIDTH'($urandom), 1, -1, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
